dma_descriptor_slave: RTL and testbench

Avalon-MM slave endpoint for the descriptor-controller (DCS) port that the DMA request path drives. It accepts the five-word descriptor write sequence at byte addresses 0x00–0x10 and assembles each sequence into a 160-bit descriptor. It queues completed descriptors in a DEPTH-entry FIFO and presents them to the DMA engine over a valid/ready handshake. It back-pressures the master with waitrequest when the queue is full, and it exposes a readable status register.

---
 rtl/dma_descriptor_slave.sv | 163 ++++++++++++++++
 tb/tb_dma_descriptor_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_descriptor_slave.sv
// Avalon-MM slave that assembles five-word DMA descriptors, queues them in a
// DEPTH-entry FIFO and hands them to the DMA engine over valid/ready.
module dma_descriptor_slave #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DCSChipSelect,
  input  logic        DCSWrite,
  input  logic        DCSRead,
  input  logic [7:0]  DCSAddress,
  input  logic [31:0] DCSWriteData,
  input  logic [3:0]  DCSByteEnable,
  output logic        DCSWaitRequest,
  output logic [31:0] DCSReadData,
  output logic        DescValid,
  input  logic        DescReady,
  output logic [63:0] DescStatusAddr,
  output logic [63:0] DescDataAddr,
  output logic [3:0]  DescLength
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  // Only word4[2:0] of the last word is ever consumed downstream.
  localparam int unsigned DESC_W = 4 * 32 + 3;

  logic [31:0]       stage [5];
  logic [3:0]        writtenMask;
  logic              seqError;
  logic [DESC_W-1:0] fifoMem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [OCC_W-1:0]  occupancy;

  logic [5:0]        wordIdx;
  logic              full;
  logic              empty;
  logic              wrAccept;
  logic              rdAccept;
  logic              push;
  logic              pop;
  logic              seqSet;
  logic              seqClr;
  logic [31:0]       stage4Next;
  logic [DESC_W-1:0] pushEntry;
  logic [DESC_W-1:0] headEntry;
  logic [31:0]       statusWord;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = newVal[8*b +: 8];
    end
    return res;
  endfunction

  assign wordIdx   = DCSAddress[7:2];
  assign full      = (occupancy == OCC_W'(DEPTH));
  assign empty     = (occupancy == '0);
  assign DescValid = ~empty;

  assign DCSWaitRequest = DCSChipSelect & DCSWrite & (DCSAddress == 8'h10) & full;
  assign wrAccept       = DCSChipSelect & DCSWrite & ~DCSWaitRequest;
  assign rdAccept       = DCSChipSelect & DCSRead & ~DCSWrite;

  // A misaligned word-4 alias can bypass the stall; never let it overflow.
  assign push   = wrAccept & (wordIdx == 6'd4) & ~full;
  assign pop    = DescValid & DescReady;
  assign seqSet = push & (writtenMask != 4'hF);
  assign seqClr = wrAccept & (wordIdx == 6'd5) & DCSWriteData[16] & DCSByteEnable[2];

  assign stage4Next = mergeBytes(stage[4], DCSWriteData, DCSByteEnable);
  assign pushEntry  = {stage4Next[2:0], stage[3], stage[2], stage[1], stage[0]};

  assign headEntry      = fifoMem[rdPtr];
  assign DescStatusAddr = headEntry[63:0];
  assign DescDataAddr   = headEntry[127:64];
  assign DescLength     = 4'(headEntry[130:128]) + 4'd1;

  assign statusWord = {15'd0, seqError, 6'd0, empty, full, 3'd0, 5'(occupancy)};

  // Staging registers, byte-merged on each accepted word write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) stage[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wrAccept && (wordIdx == 6'(i))) begin
          stage[i] <= mergeBytes(stage[i], DCSWriteData, DCSByteEnable);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      writtenMask <= '0;
    end else if (push) begin
      writtenMask <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wrAccept && (wordIdx == 6'(i))) writtenMask[i] <= 1'b1;
      end
    end
  end

  // Sticky sequence error; a same-edge set beats the W1C clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seqError <= 1'b0;
    end else if (seqSet) begin
      seqError <= 1'b1;
    end else if (seqClr) begin
      seqError <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) fifoMem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= pushEntry;
        wrPtr          <= wrPtr + PTR_W'(1);
      end
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_comb begin
    DCSReadData = '0;
    if (rdAccept) begin
      case (wordIdx)
        6'd0:    DCSReadData = stage[0];
        6'd1:    DCSReadData = stage[1];
        6'd2:    DCSReadData = stage[2];
        6'd3:    DCSReadData = stage[3];
        6'd4:    DCSReadData = stage[4];
        6'd5:    DCSReadData = statusWord;
        default: DCSReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_descriptor_slave.sv
// Randomized bench for dma_descriptor_slave against a queue-based descriptor model.
module tb_dma_descriptor_slave;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        DCSChipSelect;
  logic        DCSWrite;
  logic        DCSRead;
  logic [7:0]  DCSAddress;
  logic [31:0] DCSWriteData;
  logic [3:0]  DCSByteEnable;
  logic        DCSWaitRequest;
  logic [31:0] DCSReadData;
  logic        DescValid;
  logic        DescReady;
  logic [63:0] DescStatusAddr;
  logic [63:0] DescDataAddr;
  logic [3:0]  DescLength;

  dma_descriptor_slave #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .DCSChipSelect  (DCSChipSelect),
    .DCSWrite       (DCSWrite),
    .DCSRead        (DCSRead),
    .DCSAddress     (DCSAddress),
    .DCSWriteData   (DCSWriteData),
    .DCSByteEnable  (DCSByteEnable),
    .DCSWaitRequest (DCSWaitRequest),
    .DCSReadData    (DCSReadData),
    .DescValid      (DescValid),
    .DescReady      (DescReady),
    .DescStatusAddr (DescStatusAddr),
    .DescDataAddr   (DescDataAddr),
    .DescLength     (DescLength)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: staging words, written mask, sticky error, descriptor queue
  logic [31:0]  mStage [5];
  logic [3:0]   mMask;
  bit           mSeqErr;
  logic [159:0] mQ [$];
  bit           randReady;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] applyBe(input logic [31:0] oldVal, input logic [31:0] newVal,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = oldVal;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = newVal[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mStatus();
    int occ;
    logic [31:0] s;
    occ = mQ.size();
    s = 32'(occ);
    if (occ == DEPTH) s = s | 32'h100;
    if (occ == 0)     s = s | 32'h200;
    if (mSeqErr)      s = s | 32'h10000;
    return s;
  endfunction

  function automatic logic [31:0] mRead(input logic [7:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 5)  return mStage[idx];
    if (idx == 5) return mStatus();
    return 32'd0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 5; i++) mStage[i] = '0;
    mMask   = '0;
    mSeqErr = 0;
    mQ.delete();
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic stepCycle(output bit accepted);
    bit expWait, wrAcc, rdAcc, popNow, setNow, clrNow;
    logic [159:0] head;
    int idx;
    if (randReady) DescReady = ($urandom_range(0, 1) == 1);
    @(negedge clock);
    expWait = DCSChipSelect && DCSWrite && (DCSAddress == 8'h10) && (mQ.size() == DEPTH);
    checkVal("waitrequest", DCSWaitRequest, expWait);
    checkVal("desc_valid", DescValid, mQ.size() != 0);
    if (mQ.size() != 0) begin
      head = mQ[0];
      checkVal("desc_status_addr", DescStatusAddr, head[63:0]);
      checkVal("desc_data_addr", DescDataAddr, head[127:64]);
      checkVal("desc_length", DescLength, 64'(head[130:128]) + 64'd1);
    end
    rdAcc = DCSChipSelect && DCSRead && !DCSWrite;
    checkVal("read_data", DCSReadData, rdAcc ? mRead(DCSAddress) : 32'd0);
    wrAcc  = DCSChipSelect && DCSWrite && !expWait;
    popNow = (mQ.size() != 0) && DescReady;
    @(posedge clock);
    setNow = 0;
    clrNow = 0;
    if (popNow) void'(mQ.pop_front());
    if (wrAcc) begin
      idx = int'(DCSAddress) / 4;
      if (idx < 4) begin
        mStage[idx] = applyBe(mStage[idx], DCSWriteData, DCSByteEnable);
        mMask[idx]  = 1'b1;
      end else if (idx == 4) begin
        mStage[4] = applyBe(mStage[4], DCSWriteData, DCSByteEnable);
        mQ.push_back({mStage[4], mStage[3], mStage[2], mStage[1], mStage[0]});
        setNow = (mMask != 4'hF);
        mMask  = '0;
      end else if (idx == 5) begin
        clrNow = DCSWriteData[16] && DCSByteEnable[2];
      end
    end
    if (setNow) mSeqErr = 1;
    else if (clrNow) mSeqErr = 0;
    #1;
    accepted = wrAcc;
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    bit acc;
    int n;
    n = 0;
    DCSChipSelect = 1; DCSWrite = 1; DCSRead = 0;
    DCSAddress = addr; DCSWriteData = data; DCSByteEnable = be;
    do begin
      stepCycle(acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) checkVal("write_timeout", 64'd0, 64'd1);
    DCSChipSelect = 0; DCSWrite = 0;
  endtask

  task automatic busRead(input logic [7:0] addr);
    bit acc;
    DCSChipSelect = 1; DCSRead = 1; DCSWrite = 0; DCSAddress = addr;
    stepCycle(acc);
    DCSChipSelect = 0; DCSRead = 0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) stepCycle(acc);
  endtask

  task automatic writeSeq(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input logic [31:0] w4);
    busWrite(8'h00, w0, 4'hF);
    busWrite(8'h04, w1, 4'hF);
    busWrite(8'h08, w2, 4'hF);
    busWrite(8'h0C, w3, 4'hF);
    busWrite(8'h10, w4, 4'hF);
  endtask

  task automatic doReset();
    reset = 0;
    modelReset();
    @(negedge clock);
    checkVal("rst_desc_valid", DescValid, 64'd0);
    checkVal("rst_status_addr", DescStatusAddr, 64'd0);
    checkVal("rst_data_addr", DescDataAddr, 64'd0);
    checkVal("rst_length", DescLength, 64'd1);
    checkVal("rst_waitrequest", DCSWaitRequest, 64'd0);
    checkVal("rst_read_data", DCSReadData, 64'd0);
    reset = 1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit acc;
    int r;
    DCSChipSelect = 0; DCSWrite = 0; DCSRead = 0;
    DCSAddress = '0; DCSWriteData = '0; DCSByteEnable = '0;
    DescReady = 0;
    randReady = 0;
    doReset();

    // Single sequence with engine ready
    DescReady = 1;
    writeSeq(32'h0000_7000, 32'h0, 32'h1234_5678, 32'h9, 32'h3);
    @(negedge clock);
    checkVal("single_valid", DescValid, 64'd1);
    checkVal("single_status", DescStatusAddr, 64'h7000);
    checkVal("single_data", DescDataAddr, 64'h0000_0009_1234_5678);
    checkVal("single_len", DescLength, 64'd4);
    @(posedge clock); #1;
    void'(mQ.pop_front());
    busRead(8'h14);

    // Fill to DEPTH, then the next 0x10 write stalls until one pop
    DescReady = 0;
    for (int s = 0; s < DEPTH; s++)
      writeSeq($urandom, $urandom, $urandom, $urandom, $urandom);
    busRead(8'h14);
    busWrite(8'h00, $urandom, 4'hF);
    busWrite(8'h04, $urandom, 4'hF);
    busWrite(8'h08, $urandom, 4'hF);
    busWrite(8'h0C, $urandom, 4'hF);
    DCSChipSelect = 1; DCSWrite = 1; DCSAddress = 8'h10; DCSWriteData = $urandom; DCSByteEnable = 4'hF;
    stepCycle(acc);
    checkVal("stall_held", acc, 64'd0);
    stepCycle(acc);
    DescReady = 1;
    stepCycle(acc);
    DescReady = 0;
    stepCycle(acc);
    checkVal("stall_released", acc, 64'd1);
    DCSChipSelect = 0; DCSWrite = 0;
    busRead(8'h14);
    DescReady = 1;
    idle(DEPTH + 1);

    // Byte enables
    busWrite(8'h08, 32'h0, 4'hF);
    busWrite(8'h08, 32'hAABB_CCDD, 4'b0101);
    busRead(8'h08);

    // Clean slate so a lone 0x10 write is an incomplete sequence
    DescReady = 0;
    doReset();
    busWrite(8'h10, 32'h7, 4'hF);
    @(negedge clock);
    checkVal("seqerr_len8", DescLength, 64'd8);
    @(posedge clock); #1;
    busRead(8'h14);
    busWrite(8'h14, 32'h0001_0000, 4'b0100);
    busRead(8'h14);
    DescReady = 1;
    idle(2);

    // Push and pop on the same edge at occupancy 2
    DescReady = 0;
    writeSeq($urandom, $urandom, $urandom, $urandom, $urandom);
    writeSeq($urandom, $urandom, $urandom, $urandom, $urandom);
    busWrite(8'h00, $urandom, 4'hF);
    busWrite(8'h04, $urandom, 4'hF);
    busWrite(8'h08, $urandom, 4'hF);
    busWrite(8'h0C, $urandom, 4'hF);
    DescReady = 1;
    busWrite(8'h10, $urandom, 4'hF);
    DescReady = 0;
    busRead(8'h14);
    DescReady = 1;
    idle(3);

    // Reset mid-sequence with two entries queued
    DescReady = 0;
    writeSeq($urandom, $urandom, $urandom, $urandom, $urandom);
    writeSeq($urandom, $urandom, $urandom, $urandom, $urandom);
    busWrite(8'h00, $urandom, 4'hF);
    busWrite(8'h04, $urandom, 4'hF);
    busWrite(8'h08, $urandom, 4'hF);
    doReset();
    for (int a = 0; a < 6; a++) busRead(8'(a * 4));
    writeSeq($urandom, $urandom, $urandom, $urandom, $urandom);
    busRead(8'h14);
    DescReady = 1;
    idle(2);
    busRead(8'h14);

    // Randomized traffic with random engine back-pressure
    randReady = 1;
    for (int op = 0; op < 400; op++) begin
      r = $urandom_range(0, 11);
      if (r <= 6)
        busWrite(8'($urandom_range(0, 4) * 4), $urandom, 4'($urandom_range(0, 15)));
      else if (r == 7)
        busWrite(8'h14, $urandom_range(0, 1) ? 32'h0001_0000 : 32'h0, 4'($urandom_range(0, 15)));
      else if (r == 8)
        busWrite(8'($urandom_range(6, 63) * 4), $urandom, 4'hF);
      else if (r <= 10)
        busRead(8'($urandom_range(0, 7) * 4));
      else
        idle(1);
    end
    randReady = 0;
    DescReady = 1;
    idle(DEPTH + 2);
    busRead(8'h14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
